// File: rtl/coreaxi4dmacontroller_rd_tran_queue.sv
`default_nettype none
// ============================================================================
// Module  : coreaxi4dmacontroller_rd_tran_queue
// Purpose : In-order AXI4 DMA read-transaction queue (push / issue / retire).
//           Optional macro RD_TRAN_Q_ERR_STICKY_EN keeps a per-entry error bit.
// Revision: 1.0 - initial release
// ============================================================================
module coreaxi4dmacontroller_rd_tran_queue #(
    parameter int ID_WIDTH      = 5,
    parameter int NUM_PRI_LVLS  = 1,
    parameter int MAX_TRAN_SIZE = 23,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESETN,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ID_WIDTH-1:0]          push_id,
    input  logic [31:0]                  push_src_addr,
    input  logic [MAX_TRAN_SIZE-1:0]     push_byte_cnt,
    input  logic [1:0]                   push_burst,
    input  logic [NUM_PRI_LVLS-1:0]      push_pri,
    input  logic                         push_strm_dscrptr,
    input  logic                         push_last,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [ID_WIDTH-1:0]          issue_id,
    output logic [31:0]                  issue_src_addr,
    output logic [MAX_TRAN_SIZE-1:0]     issue_byte_cnt,
    output logic [1:0]                   issue_burst,
    output logic [NUM_PRI_LVLS-1:0]      issue_pri,
    input  logic                         rd_beat_valid,
    input  logic                         rd_beat_last,
    input  logic                         rd_beat_err,
    input  logic                         flush,
    output logic                         retire_valid,
    output logic [ID_WIDTH-1:0]          retire_id,
    output logic                         retire_err,
    output logic                         retire_strm_dscrptr,
    output logic                         retire_last,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy,
    output logic                         orphan_beat
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ID_WIDTH-1:0]      q_id    [QUEUE_DEPTH];
    logic [31:0]              q_addr  [QUEUE_DEPTH];
    logic [MAX_TRAN_SIZE-1:0] q_cnt   [QUEUE_DEPTH];
    logic [1:0]               q_burst [QUEUE_DEPTH];
    logic [NUM_PRI_LVLS-1:0]  q_pri   [QUEUE_DEPTH];
    logic                     q_strm  [QUEUE_DEPTH];
    logic                     q_last  [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr, iss_ptr, ret_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, iss_ptr_nxt;
    logic [PTR_W-1:0] pending, outstanding;
    logic [IDX_W-1:0] wr_idx, iss_idx, ret_idx;
    logic             push_fire, issue_fire, beat_ok, retire_fire;
    logic             beat_err_total;

    assign wr_idx  = wr_ptr[IDX_W-1:0];
    assign iss_idx = iss_ptr[IDX_W-1:0];
    assign ret_idx = ret_ptr[IDX_W-1:0];

    // The extra pointer MSB makes the differences below unambiguous at full/empty.
    assign occupancy   = wr_ptr - ret_ptr;
    assign pending     = wr_ptr - iss_ptr;
    assign outstanding = iss_ptr - ret_ptr;

    assign push_ready  = (occupancy < PTR_W'(QUEUE_DEPTH)) & ~flush;
    assign issue_valid = (pending != '0);
    assign push_fire   = push_valid & push_ready;
    assign issue_fire  = issue_valid & issue_ready;
    assign beat_ok     = rd_beat_valid & (outstanding != '0);
    assign retire_fire = beat_ok & rd_beat_last;

    assign issue_id       = q_id[iss_idx];
    assign issue_src_addr = q_addr[iss_idx];
    assign issue_byte_cnt = q_cnt[iss_idx];
    assign issue_burst    = q_burst[iss_idx];
    assign issue_pri      = q_pri[iss_idx];

    // Flush rewinds the write pointer onto the post-issue pointer so a
    // same-cycle handshake still turns its entry into Issued.
    assign iss_ptr_nxt = iss_ptr + PTR_W'(issue_fire);
    assign wr_ptr_nxt  = flush ? iss_ptr_nxt : (wr_ptr + PTR_W'(push_fire));

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            ret_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_id[i]    <= '0;
                q_addr[i]  <= '0;
                q_cnt[i]   <= '0;
                q_burst[i] <= '0;
                q_pri[i]   <= '0;
                q_strm[i]  <= 1'b0;
                q_last[i]  <= 1'b0;
            end
        end else begin
            if (push_fire) begin
                q_id[wr_idx]    <= push_id;
                q_addr[wr_idx]  <= push_src_addr;
                q_cnt[wr_idx]   <= push_byte_cnt;
                q_burst[wr_idx] <= push_burst;
                q_pri[wr_idx]   <= push_pri;
                q_strm[wr_idx]  <= push_strm_dscrptr;
                q_last[wr_idx]  <= push_last;
            end
            wr_ptr  <= wr_ptr_nxt;
            iss_ptr <= iss_ptr_nxt;
            ret_ptr <= ret_ptr + PTR_W'(retire_fire);
        end
    end

`ifdef RD_TRAN_Q_ERR_STICKY_EN
    logic q_err [QUEUE_DEPTH];

    // A pushed slot never aliases the head of the issued region, so the
    // clear-on-push and set-on-beat writes cannot collide.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_err[i] <= 1'b0;
            end
        end else begin
            if (push_fire) begin
                q_err[wr_idx] <= 1'b0;
            end
            if (beat_ok && rd_beat_err) begin
                q_err[ret_idx] <= 1'b1;
            end
        end
    end

    assign beat_err_total = q_err[ret_idx] | rd_beat_err;
`else
    assign beat_err_total = rd_beat_err;
`endif

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            retire_valid        <= 1'b0;
            retire_id           <= '0;
            retire_err          <= 1'b0;
            retire_strm_dscrptr <= 1'b0;
            retire_last         <= 1'b0;
            orphan_beat         <= 1'b0;
        end else begin
            retire_valid <= retire_fire;
            if (retire_fire) begin
                retire_id           <= q_id[ret_idx];
                retire_err          <= beat_err_total;
                retire_strm_dscrptr <= q_strm[ret_idx];
                retire_last         <= q_last[ret_idx];
            end
            if (rd_beat_valid && (outstanding == '0)) begin
                orphan_beat <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
